// File: rtl/event_timestamp_fifo.sv
// ============================================================================
// Module  : event_timestamp_fifo
// Brief   : Timestamps classified events and buffers them for valid/ready
//           readout; counts events dropped on overflow.
// Revision: 1.0
// ============================================================================
`default_nettype none

module event_timestamp_fifo #(
  parameter int DATA_W = 32,
  parameter int TS_W   = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int OVF_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      event_in,
  input  logic                   event_valid,
  output logic [TS_W+DATA_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W:0]        fifo_count,
  output logic [OVF_W-1:0]       overflow_cnt,
  output logic                   ts_wrap
);

  localparam int              c_ENTRY_W   = TS_W + DATA_W;
  localparam logic [ADDR_W:0] c_DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] c_ONE_CNT   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] c_PTR_ONE = ADDR_W'(1);
  localparam logic [OVF_W-1:0] c_OVF_MAX  = '1;
  localparam logic [TS_W-1:0]  c_TS_MAX   = '1;

  logic [c_ENTRY_W-1:0] mem_q [DEPTH];

  logic [TS_W-1:0]      ts_q;
  logic                 ts_wrap_q;
  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]      count_q, count_d;
  logic [OVF_W-1:0]     ovf_q, ovf_d;
  logic [c_ENTRY_W-1:0] head_q, head_d;
  logic                 head_valid_q, head_valid_d;

  logic                 w_pop;
  logic                 w_full;
  logic                 w_push;
  logic                 w_drop;
  logic [c_ENTRY_W-1:0] w_entry;
  logic [ADDR_W-1:0]    w_rd_next;

  assign w_pop     = head_valid_q && out_ready;
  assign w_full    = (count_q == c_DEPTH_CNT);
  assign w_push    = event_valid && (!w_full || w_pop);
  assign w_drop    = event_valid && w_full && !w_pop;
  assign w_entry   = {ts_q, event_in};
  assign w_rd_next = rd_ptr_q + c_PTR_ONE;

  always_comb begin
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    ovf_d        = ovf_q;
    head_d       = head_q;

    if (w_push && !w_pop) begin
      count_d = count_q + c_ONE_CNT;
    end else if (w_pop && !w_push) begin
      count_d = count_q - c_ONE_CNT;
    end

    if (w_push) begin
      wr_ptr_d = wr_ptr_q + c_PTR_ONE;
    end
    if (w_pop) begin
      rd_ptr_d = w_rd_next;
    end

    // Head register always mirrors mem_q[rd_ptr]; bypass the write when the
    // incoming entry becomes the new head in the same edge.
    if (w_pop) begin
      if (count_q == c_ONE_CNT) begin
        if (w_push) begin
          head_d = w_entry;
        end
      end else begin
        head_d = mem_q[w_rd_next];
      end
    end else if ((count_q == '0) && w_push) begin
      head_d = w_entry;
    end

    head_valid_d = (count_d != '0);

    if (w_drop && (ovf_q != c_OVF_MAX)) begin
      ovf_d = ovf_q + OVF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q         <= '0;
      ts_wrap_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      ts_q         <= ts_q + TS_W'(1);
      ts_wrap_q    <= (ts_q == c_TS_MAX);
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
    end
  end

  // Storage is not reset: entries are only reachable through count_q.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= w_entry;
    end
  end

  assign out_data     = head_q;
  assign out_valid    = head_valid_q;
  assign fifo_count   = count_q;
  assign overflow_cnt = ovf_q;
  assign ts_wrap      = ts_wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_event_timestamp_fifo.sv
// ============================================================================
// Module  : tb_event_timestamp_fifo
// Brief   : Directed self-checking bench for event_timestamp_fifo.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_event_timestamp_fifo;

  logic        clk;
  logic        rst;
  logic [31:0] event_in;
  logic        event_valid;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  fifo_count;
  logic [15:0] overflow_cnt;
  logic        ts_wrap;

  int          errors;
  int          checks;
  logic [31:0] ts_m;
  logic [31:0] tsv [16];
  logic [31:0] ts_new;
  logic [31:0] ts_a;
  logic [31:0] ts_b;

  event_timestamp_fifo #(
    .DATA_W(32), .TS_W(32), .DEPTH(16), .ADDR_W(4), .OVF_W(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .event_in    (event_in),
    .event_valid (event_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .fifo_count  (fifo_count),
    .overflow_cnt(overflow_cnt),
    .ts_wrap     (ts_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle; ts_m tracks the expected timestamp.
  task automatic step();
    @(posedge clk);
    #1;
    if (rst) ts_m = ts_m + 32'd1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors      = 0;
    checks      = 0;
    ts_m        = '0;
    rst         = 1'b0;
    event_in    = '0;
    event_valid = 1'b0;
    out_ready   = 1'b0;

    // Reset state
    repeat (2) step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_ovf",   64'(overflow_cnt), 64'd0);
    chk("rst_data",  out_data, 64'd0);
    chk("rst_wrap",  64'(ts_wrap), 64'd0);

    // Test 1: push at ts=5
    rst  = 1'b1;
    ts_m = '0;
    repeat (5) step();
    event_in = 32'h0000_00A1; event_valid = 1'b1;
    step();
    event_valid = 1'b0;
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_data",  out_data, 64'h0000_0005_0000_00A1);
    chk("t1_count", 64'(fifo_count), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t1_pop_valid", 64'(out_valid), 64'd0);
    chk("t1_pop_count", 64'(fifo_count), 64'd0);

    // Test 2: fill 16, then two dropped
    event_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      event_in = 32'h100 + 32'(i);
      tsv[i]   = ts_m;
      step();
    end
    event_in = 32'h1EE; step();
    event_in = 32'h1EF; step();
    event_valid = 1'b0;
    chk("t2_count", 64'(fifo_count), 64'd16);
    chk("t2_ovf",   64'(overflow_cnt), 64'd2);
    chk("t2_valid", 64'(out_valid), 64'd1);
    chk("t2_head",  out_data, {tsv[0], 32'h100});

    // Test 3: full with simultaneous push/pop
    event_in = 32'h1FF; event_valid = 1'b1; out_ready = 1'b1;
    ts_new = ts_m;
    step();
    event_valid = 1'b0; out_ready = 1'b0;
    chk("t3_count", 64'(fifo_count), 64'd16);
    chk("t3_ovf",   64'(overflow_cnt), 64'd2);
    chk("t3_head",  out_data, {tsv[1], 32'h101});

    out_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("t2_drain", out_data, {tsv[i], 32'h100 + 32'(i)});
      step();
    end
    chk("t3_last", out_data, {ts_new, 32'h1FF});
    chk("t3_last_valid", 64'(out_valid), 64'd1);
    step();
    out_ready = 1'b0;
    chk("t3_empty_valid", 64'(out_valid), 64'd0);
    chk("t3_empty_count", 64'(fifo_count), 64'd0);

    // Test 4: stall then drain one per cycle
    event_valid = 1'b1;
    event_in = 32'h401; ts_a = ts_m; step();
    event_in = 32'h402; ts_b = ts_m; step();
    event_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t4_hold_data",  out_data, {ts_a, 32'h401});
      chk("t4_hold_valid", 64'(out_valid), 64'd1);
      step();
    end
    out_ready = 1'b1;
    chk("t4_pre_pop", out_data, {ts_a, 32'h401});
    step();
    chk("t4_count1", 64'(fifo_count), 64'd1);
    chk("t4_data2",  out_data, {ts_b, 32'h402});
    step();
    out_ready = 1'b0;
    chk("t4_count0", 64'(fifo_count), 64'd0);
    chk("t4_valid0", 64'(out_valid), 64'd0);

    // Test 5: timestamp wrap
    force dut.ts_q = 32'hFFFF_FFFE;
    #1;
    release dut.ts_q;
    ts_m = 32'hFFFF_FFFE;
    event_valid = 1'b1;
    event_in = 32'hE1; step();
    chk("t5_wrap_a", 64'(ts_wrap), 64'd0);
    event_in = 32'hE2; step();
    chk("t5_wrap_b", 64'(ts_wrap), 64'd1);
    event_in = 32'hE3; step();
    chk("t5_wrap_c", 64'(ts_wrap), 64'd0);
    event_valid = 1'b0;
    chk("t5_count", 64'(fifo_count), 64'd3);
    out_ready = 1'b1;
    chk("t5_e1", out_data, 64'hFFFF_FFFE_0000_00E1);
    step();
    chk("t5_e2", out_data, 64'hFFFF_FFFF_0000_00E2);
    step();
    chk("t5_e3", out_data, 64'h0000_0000_0000_00E3);
    step();
    out_ready = 1'b0;
    chk("t5_empty", 64'(out_valid), 64'd0);

    // Test 6: asynchronous reset mid-stream
    event_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      event_in = 32'h600 + 32'(i);
      step();
    end
    event_valid = 1'b0;
    chk("t6_count7", 64'(fifo_count), 64'd7);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_count", 64'(fifo_count), 64'd0);
    chk("t6_rst_ovf",   64'(overflow_cnt), 64'd0);
    chk("t6_rst_data",  out_data, 64'd0);
    repeat (2) step();
    rst  = 1'b1;
    ts_m = '0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("t6_post_valid", 64'(out_valid), 64'd0);
    chk("t6_post_count", 64'(fifo_count), 64'd0);
    out_ready = 1'b0;
    event_in = 32'h7A; event_valid = 1'b1;
    step();
    event_valid = 1'b0;
    chk("t6_new_data",  out_data, 64'h0000_0003_0000_007A);
    chk("t6_new_count", 64'(fifo_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
